// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer and dat_mem port owner for the 9-bit core.
// Optional watchdog (TIMEOUT state) enabled by defining RUN_WATCHDOG_EN.
`default_nettype none

module core_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_start,
  output logic             host_busy,
  output logic             host_done,
  output logic             host_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic             core_start,
  input  logic             core_done,
  input  logic             core_mem_wr_en,
  input  logic [7:0]       core_mem_addr,
  input  logic [7:0]       core_mem_wdata,
  input  logic             host_mem_req,
  input  logic             host_mem_we,
  input  logic [7:0]       host_mem_addr,
  input  logic [7:0]       host_mem_wdata,
  output logic             host_mem_gnt,
  output logic [7:0]       host_mem_rdata,
  output logic             mem_wr_en,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_CORE = 3'd1,
    S_RUN        = 3'd2,
    S_DONE       = 3'd3,
    S_TIMEOUT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             core_start_q, host_busy_q, host_done_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (host_start) begin
          state_d   = S_RESET_CORE;
          rst_cnt_d = '0;
          cnt_d     = '0;
        end
      end
      S_RESET_CORE: begin
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        else                       rst_cnt_d = rst_cnt_q + RW'(1);
      end
      S_RUN: begin
        // The count includes the exit edge, so the limit is tested on the incremented value.
        cnt_d = cnt_inc;
        if (core_done) state_d = S_DONE;
`ifdef RUN_WATCHDOG_EN
        else if (cnt_inc == CNT_MAX) state_d = S_TIMEOUT;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cnt_q        <= '0;
      core_start_q <= 1'b1;
      host_busy_q  <= 1'b0;
      host_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cnt_q        <= cnt_d;
      core_start_q <= (state_d != S_RUN);
      host_busy_q  <= (state_d == S_RESET_CORE) || (state_d == S_RUN);
      host_done_q  <= (state_d == S_DONE);
    end
  end

`ifdef RUN_WATCHDOG_EN
  logic host_timeout_q;
  always_ff @(posedge clk) begin
    if (!reset) host_timeout_q <= 1'b0;
    else        host_timeout_q <= (state_d == S_TIMEOUT);
  end
  assign host_timeout = host_timeout_q;
`else
  assign host_timeout = 1'b0;
`endif

  assign core_start  = core_start_q;
  assign host_busy   = host_busy_q;
  assign host_done   = host_done_q;
  assign cycle_count = cnt_q;

  logic core_owns;
  assign core_owns = (state_q == S_RESET_CORE) || (state_q == S_RUN);

  always_comb begin
    host_mem_gnt   = 1'b0;
    host_mem_rdata = 8'h00;
    mem_wr_en      = 1'b0;
    mem_addr       = 8'h00;
    mem_wdata      = 8'h00;
    if (core_owns) begin
      mem_wr_en = core_mem_wr_en;
      mem_addr  = core_mem_addr;
      mem_wdata = core_mem_wdata;
    end else if (host_mem_req && !host_start) begin
      host_mem_gnt   = 1'b1;
      host_mem_rdata = mem_rdata;
      mem_wr_en      = host_mem_we;
      mem_addr       = host_mem_addr;
      mem_wdata      = host_mem_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: cycle model plus directed literal checks.
`default_nettype none

module tb_core_run_ctrl;

  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 4;
  localparam int LIMIT      = (1 << CNT_W) - 1;
`ifdef RUN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             host_start;
  logic             host_busy, host_done, host_timeout;
  logic [CNT_W-1:0] cycle_count;
  logic             core_start;
  logic             core_done;
  logic             core_mem_wr_en;
  logic [7:0]       core_mem_addr, core_mem_wdata;
  logic             host_mem_req, host_mem_we;
  logic [7:0]       host_mem_addr, host_mem_wdata;
  logic             host_mem_gnt;
  logic [7:0]       host_mem_rdata;
  logic             mem_wr_en;
  logic [7:0]       mem_addr, mem_wdata, mem_rdata;

  core_run_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .host_start(host_start),
    .host_busy(host_busy), .host_done(host_done), .host_timeout(host_timeout),
    .cycle_count(cycle_count), .core_start(core_start), .core_done(core_done),
    .core_mem_wr_en(core_mem_wr_en), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .host_mem_req(host_mem_req),
    .host_mem_we(host_mem_we), .host_mem_addr(host_mem_addr),
    .host_mem_wdata(host_mem_wdata), .host_mem_gnt(host_mem_gnt),
    .host_mem_rdata(host_mem_rdata), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dat_mem stand-in: synchronous write, combinational read
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the run plus plain integer counters.
  localparam int M_IDLE = 0, M_PREP = 1, M_RUN = 2, M_DONE = 3, M_TO = 4;
  int mode = M_IDLE;
  int rst_left = 0;
  int run_cycles = 0;

  always @(posedge clk) begin
    if (!reset) begin
      mode = M_IDLE;
      run_cycles = 0;
    end else if (mode == M_PREP) begin
      rst_left = rst_left - 1;
      if (rst_left == 0) mode = M_RUN;
    end else if (mode == M_RUN) begin
      if (run_cycles < LIMIT) run_cycles = run_cycles + 1;
      if (core_done) mode = M_DONE;
      else if (WD && run_cycles == LIMIT) mode = M_TO;
    end else if (host_start) begin
      mode = M_PREP;
      rst_left = RST_CYCLES;
      run_cycles = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit host_owns, gnt;
      logic [7:0] e_addr, e_wdata, e_rdata;
      logic e_we;
      host_owns = !(mode == M_PREP || mode == M_RUN);
      gnt = host_owns && host_mem_req && !host_start;
      e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00; e_rdata = 8'h00;
      if (!host_owns) begin
        e_we = core_mem_wr_en; e_addr = core_mem_addr; e_wdata = core_mem_wdata;
      end else if (gnt) begin
        e_we = host_mem_we; e_addr = host_mem_addr; e_wdata = host_mem_wdata;
        e_rdata = mem_rdata;
      end
      cmp("status{start,busy,done,tmo}",
          32'({core_start, host_busy, host_done, host_timeout}),
          32'({mode != M_RUN, !host_owns, mode == M_DONE, mode == M_TO}));
      cmp("cycle_count", 32'(cycle_count), 32'(run_cycles));
      cmp("mem_bus{gnt,we,addr,wdata,rdata}",
          32'({host_mem_gnt, mem_wr_en, mem_addr, mem_wdata, host_mem_rdata}),
          32'({gnt, e_we, e_addr, e_wdata, e_rdata}));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0; host_start = 1'b0; core_done = 1'b0;
    core_mem_wr_en = 1'b0; core_mem_addr = 8'h00; core_mem_wdata = 8'h00;
    host_mem_req = 1'b0; host_mem_we = 1'b0; host_mem_addr = 8'h00; host_mem_wdata = 8'h00;
    step();
    chk_en = 1'b1;
    step(); step();
    cmp("reset core_start", 32'(core_start), 32'd1);
    cmp("reset cycle_count", 32'(cycle_count), 32'd0);
    cmp("reset status", 32'({host_busy, host_done, host_timeout}), 32'd0);
    reset = 1'b1;
    step();

    // Host write then read in IDLE
    host_mem_req = 1'b1; host_mem_we = 1'b1; host_mem_addr = 8'h10; host_mem_wdata = 8'h5A;
    #1;
    cmp("idle write gnt", 32'(host_mem_gnt), 32'd1);
    cmp("idle write wr_en", 32'(mem_wr_en), 32'd1);
    step();
    host_mem_we = 1'b0; host_mem_wdata = 8'h00;
    #1;
    cmp("idle read gnt", 32'(host_mem_gnt), 32'd1);
    cmp("idle read rdata", 32'(host_mem_rdata), 32'h5A);
    step();
    host_mem_req = 1'b0; host_mem_addr = 8'h00;

    // Start, two prep cycles, done on 7th run cycle; host access attempt in run cycle 2
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    #1;
    cmp("prep core_start", 32'(core_start), 32'd1);
    step(); step();
    cmp("run core_start", 32'(core_start), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin
        host_start = 1'b1; host_mem_req = 1'b1; host_mem_we = 1'b1;
        host_mem_addr = 8'h33; host_mem_wdata = 8'hEE;
        core_mem_wr_en = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h77;
        #1;
        cmp("run host gnt", 32'(host_mem_gnt), 32'd0);
        cmp("run mem_addr from core", 32'(mem_addr), 32'h20);
      end
      if (k == 7) core_done = 1'b1;
      step();
      host_start = 1'b0; host_mem_req = 1'b0; host_mem_we = 1'b0;
      host_mem_addr = 8'h00; host_mem_wdata = 8'h00;
      core_mem_wr_en = 1'b0; core_mem_addr = 8'h00; core_mem_wdata = 8'h00;
      core_done = 1'b0;
    end
    cmp("done host_done", 32'(host_done), 32'd1);
    cmp("done cycle_count", 32'(cycle_count), 32'd7);
    cmp("done core_start", 32'(core_start), 32'd1);

    // In DONE: core write blocked, host reads back the core's earlier write
    core_mem_wr_en = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h11;
    host_mem_req = 1'b1; host_mem_addr = 8'h20;
    #1;
    cmp("done read core data", 32'(host_mem_rdata), 32'h77);
    step();
    core_mem_wr_en = 1'b0; core_mem_addr = 8'h00; core_mem_wdata = 8'h00;

    // Same-cycle start and host access: start wins, no grant
    host_start = 1'b1;
    #1;
    cmp("start vs req gnt", 32'(host_mem_gnt), 32'd0);
    step();
    host_start = 1'b0; host_mem_req = 1'b0; host_mem_addr = 8'h00;
    core_done = 1'b1;
    #1;
    cmp("restart busy/done", 32'({host_busy, host_done}), 32'b10);
    step();
    step();
    core_done = 1'b0;

    // Watchdog: no done for 15 run cycles
    repeat (15) step();
    cmp("watchdog cycle_count", 32'(cycle_count), 32'd15);
    cmp("watchdog host_timeout", 32'(host_timeout), 32'(WD));
    repeat (2) step();
    cmp("saturated cycle_count", 32'(cycle_count), 32'd15);

`ifdef RUN_WATCHDOG_EN
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    repeat (RST_CYCLES + 3) step();
`endif
    // Reset mid-run
    reset = 1'b0;
    step();
    cmp("midrun reset core_start", 32'(core_start), 32'd1);
    cmp("midrun reset cycle_count", 32'(cycle_count), 32'd0);
    cmp("midrun reset busy", 32'(host_busy), 32'd0);
    reset = 1'b1;
    step();
    host_mem_req = 1'b1; host_mem_addr = 8'h10;
    #1;
    cmp("final read", 32'(host_mem_rdata), 32'h5A);
    step();
    host_mem_req = 1'b0; host_mem_addr = 8'h00;
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run sequencer and data-memory owner for the single-cycle 9-bit core (PC, instr_ROM, control, decoder, reg_file, alu, dat_mem).
- Holds the core in reset and releases it on a host start pulse.
- Counts execution cycles and detects program completion or a watchdog timeout.
- Arbitrates the single dat_mem port: the host owns it outside a run, the core owns it during a run.

Parameters:
RST_CYCLES, 2, cycles core_start is held high after an accepted start; must be >= 1
CNT_W, 16, width of cycle_count and of the watchdog limit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
host_start  in  1  single-cycle request to run the program
host_busy  out  1  high in RESET_CORE and RUN
host_done  out  1  high in DONE
host_timeout  out  1  high in TIMEOUT
cycle_count  out  CNT_W  RUN cycles of the last or current run
core_start  out  1  core reset (core's active-high start input)
core_done  in  1  core PC done flag
core_mem_wr_en  in  1  core dat_mem write enable
core_mem_addr  in  8  core dat_mem address
core_mem_wdata  in  8  core dat_mem write data
host_mem_req  in  1  host memory access request
host_mem_we  in  1  host write (1) or read (0)
host_mem_addr  in  8  host address
host_mem_wdata  in  8  host write data
host_mem_gnt  out  1  host access performed this cycle
host_mem_rdata  out  8  read data; 0 when not granted
mem_wr_en  out  1  to dat_mem wr_en
mem_addr  out  8  to dat_mem addr
mem_wdata  out  8  to dat_mem dat_in
mem_rdata  in  8  from dat_mem dat_out (combinational read)

Behaviour:
- Reset (reset==0 at a clk edge, from any state, including mid-run):
  - state=IDLE, core_start=1, cycle_count=0.
  - host_done=0, host_timeout=0, host_busy=0.
- States: IDLE, RESET_CORE, RUN, DONE, TIMEOUT. Outputs are decoded from registered state and counters.
- IDLE:
  - core_start=1.
  - host_start -> RESET_CORE; rst counter=0; cycle_count cleared to 0.
- RESET_CORE:
  - core_start=1; rst counter increments each cycle.
  - After exactly RST_CYCLES cycles in the state -> RUN.
  - host_start and core_done are ignored.
- RUN:
  - core_start=0.
  - cycle_count increments on every edge taken while in RUN, including the exit edge. A done in the first RUN cycle therefore gives cycle_count=1.
  - core_done=1 -> DONE.
  - cycle_count==all-ones and core_done=0 -> TIMEOUT; cycle_count holds at all-ones (saturates).
  - core_done and the limit in the same cycle: DONE wins.
  - host_start is ignored.
- DONE / TIMEOUT:
  - core_start=1; cycle_count is frozen.
  - host_start -> RESET_CORE with cycle_count cleared; host_done/host_timeout drop on the same edge.
- core_done is ignored outside RUN.
- Memory ownership (combinational):
  - Core owns the port in RESET_CORE and RUN: mem_* = core_mem_*; host_mem_gnt=0; host_mem_rdata=0.
  - Host owns the port in IDLE, DONE and TIMEOUT.
  - host_mem_gnt = host_mem_req & ~host_start. Start has priority over a same-cycle host access; the host retries next cycle and gets no grant.
  - When granted: mem_wr_en=host_mem_we, mem_addr=host_mem_addr, mem_wdata=host_mem_wdata, host_mem_rdata=mem_rdata.
  - When not granted in a host state: mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Core writes never reach dat_mem outside RESET_CORE/RUN.

Optional Feature:
Macro RUN_WATCHDOG_EN.
- Defined: TIMEOUT state and host_timeout behave as above.
- Undefined:
  - No TIMEOUT state; host_timeout tied 0.
  - RUN exits only on core_done.
  - cycle_count saturates at all-ones and the run continues.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> state IDLE, core_start=1, cycle_count=0, all host status outputs 0.
2. In IDLE: host writes 0x5A to addr 0x10, then reads addr 0x10 -> host_mem_gnt=1 both cycles, mem_wr_en=1 on the write, host_mem_rdata=0x5A.
3. host_start pulse, RST_CYCLES=2 -> core_start high 2 more cycles then low; core_done raised on the 7th RUN cycle -> host_done=1, cycle_count=7, core_start=1 next cycle.
4. During RUN assert host_mem_req with we=1 and core_mem_wr_en=1, addr 0x20 -> host_mem_gnt=0, mem_addr=0x20 from core; host_start pulse ignored.
5. Watchdog, CNT_W=4, core_done never asserted -> TIMEOUT after 15 RUN cycles, host_timeout=1, cycle_count=15. Without RUN_WATCHDOG_EN: stays RUN, cycle_count=15.
6. Assert reset=0 mid-RUN -> IDLE next edge, core_start=1, cycle_count=0. Same-cycle host_start and host_mem_req in DONE -> no grant, RESET_CORE entered.
